wptr_full_gen: RTL and testbench
================================

Name: wptr_full_gen

Overview:
- Write-side pointer and flag generator for the dual-clock FIFO. Runs entirely in the wclk domain.
- Consumes the 2-flop-synchronized Gray read pointer (wq2_rptr) and produces:
  - the memory write address and write enable;
  - the Gray write pointer that is sent to the read-clock synchronizer;
  - registered full, almost-full and fill-level outputs.

Parameters:
- ADDRSIZE, 4, FIFO address width; depth DEPTH = 2**ADDRSIZE; must be >= 2.
- AFULL_MARGIN, 2, wafull asserts when level >= DEPTH - AFULL_MARGIN; range 1..DEPTH-1.

Ports:
- wclk  in  1  write clock.
- wrst_n  in  1  reset; asynchronous, active-low; clock wclk.
- winc  in  1  write request from producer.
- wq2_rptr  in  ADDRSIZE+1  Gray read pointer, already synchronized to wclk.
- wen  out  1  memory write strobe; combinational, = winc & ~wfull.
- waddr  out  ADDRSIZE  memory write address; low bits of the binary pointer.
- wptr  out  ADDRSIZE+1  registered Gray write pointer, to the read-side synchronizer.
- wfull  out  1  registered full flag.
- wafull  out  1  registered almost-full flag.
- wlevel  out  ADDRSIZE+1  registered occupancy estimate, 0..DEPTH.
- wovf  out  1  sticky overflow flag (present only with the macro).
- wovf_clr  in  1  clears wovf (present only with the macro).

Behaviour:
- Internal state:
  - wbin: ADDRSIZE+1-bit binary write pointer.
  - wptr: Gray copy of the binary pointer.
- Next-state computation:
  - wbinnext = wbin + (winc & ~wfull), modulo 2**(ADDRSIZE+1).
  - wgraynext = (wbinnext >> 1) ^ wbinnext.
- Every wclk edge: wbin <= wbinnext; wptr <= wgraynext. wptr changes at most 1 bit per cycle, and only when a write is accepted.
- waddr = wbin[ADDRSIZE-1:0]. The write enable/address for the current cycle come from current state; the pointer advances at the end of the cycle.
- Full detection: wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - Asserts in the same edge that the last free slot is written, so a second write in the following cycle is never accepted.
- Level:
  - rbin = Gray-to-binary(wq2_rptr).
  - wlevel <= wbinnext - rbin, modulo 2**(ADDRSIZE+1).
- Almost-full: wafull <= (wbinnext - rbin) >= DEPTH - AFULL_MARGIN.
- Pessimism: wq2_rptr lags the true read pointer by 2+ wclk cycles.
  - wfull, wafull and wlevel may overstate occupancy; they never understate it.
  - Deassertion of wfull/wafull lags reads by at least 3 wclk cycles. This is correct, not a bug.
- Write while full: ignored. wen=0, and wbin/wptr/waddr are unchanged.
- Wrap-around: the extra MSB toggles every DEPTH writes. Full/empty are distinguished by the MSB plus the Gray second-MSB inversion; there is no special case.
- Simultaneous write plus pointer update: both take effect in the same edge. The flags are computed from wbinnext and the current wq2_rptr.
- Reset (asynchronous, any time, including mid-burst):
  - wbin, wptr, wlevel, wfull, wafull and wovf all go to 0 immediately.
  - wen goes to 0 because winc is expected low during reset. wen is not forced: it is combinational and still follows winc while wfull=0.
  - After release, the first write goes to waddr=0.

Optional Feature:
- Macro: WPTR_FULL_OVF_EN.
- Defined:
  - wovf and wovf_clr exist.
  - wovf <= 1 on any edge where winc & wfull. It holds until wovf_clr=1 or reset.
  - If set and clear occur in the same cycle, set wins.
- Undefined: neither port exists, and no overflow logic is built.

Decomposition:
- Shared package fifo_pkg:
  - functions bin2gray and gray2bin, parameterized via width-generic loop, used by both pointer generators;
  - constant DEFAULT_ADDRSIZE = 4.
- No sub-module; the block is a single module. The Gray conversion lives in the package functions.

Test Plan:
All scenarios use ADDRSIZE=4, AFULL_MARGIN=2.
- Reset: hold wq2_rptr=0, write 5 entries, then assert wrst_n=0 mid-cycle. Expect waddr, wptr, wlevel, wfull, wafull = 0 immediately (asynchronous). After release, the next write uses waddr=0.
- Fill: wq2_rptr=0, winc=1 for 16 cycles.
  - waddr goes 0..15; wafull=1 after the 14th write.
  - After the 16th write: wfull=1, wptr=5'b11000, wlevel=16.
- Overfill: continue winc=1 for 3 cycles while full. Expect wen=0, and wptr/waddr/wlevel unchanged. With the macro, wovf=1 until wovf_clr is pulsed.
- Drain visibility: from full, set wq2_rptr=5'b00110 (binary 4). Next edge: wfull=0, wafull=0, wlevel=12.
- Wrap: 40 writes with wq2_rptr tracking wptr delayed by 2 cycles.
  - wptr changes exactly 1 bit per accepted write.
  - The MSB of the binary pointer toggles after write 16 and write 32.
  - wfull is never asserted.
- Simultaneous: at level 15, write and advance wq2_rptr by 1 in the same cycle. Expect wlevel stays 15 and wfull stays 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer generators.
// Gray/binary conversion works on a fixed 32-bit container; callers
// zero-extend their pointer and truncate the result back to its width.
package fifo_pkg;

  localparam int DEFAULT_ADDRSIZE = 4;
  localparam int GRAY_MAX_W       = 32;

  // Binary to reflected Gray code: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    logic [GRAY_MAX_W-1:0] gray;
    gray = '0;
    for (int i = 0; i < GRAY_MAX_W - 1; i++) begin
      gray[i] = bin[i] ^ bin[i+1];
    end
    gray[GRAY_MAX_W-1] = bin[GRAY_MAX_W-1];
    return gray;
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin = '0;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/wptr_full_gen.sv
// Write-side pointer and flag generator for the dual-clock FIFO (wclk domain).
// Produces the memory write strobe/address, the Gray write pointer for the
// read-side synchronizer, and registered full / almost-full / level flags
// derived from the synchronized Gray read pointer. Because wq2_rptr lags the
// real read pointer, the flags can only overstate occupancy.
// Optional build macro WPTR_FULL_OVF_EN adds a sticky overflow flag (wovf)
// with its clear input (wovf_clr).
module wptr_full_gen
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = DEFAULT_ADDRSIZE,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                wafull,
  output logic [ADDRSIZE:0]   wlevel
`ifdef WPTR_FULL_OVF_EN
  ,
  output logic                wovf,
  input  logic                wovf_clr
`endif
);

  localparam int PTR_W = ADDRSIZE + 1;
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [PTR_W-1:0] AFULL_LEVEL = PTR_W'(DEPTH - AFULL_MARGIN);

  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] wbinnext;
  logic [PTR_W-1:0] wgraynext;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] level_next;
  logic [PTR_W-1:0] full_pattern;

  // Accept a write only while not full; address comes from the current pointer.
  assign wen   = winc & ~wfull;
  assign waddr = wbin[ADDRSIZE-1:0];

  assign wbinnext  = wbin + PTR_W'(wen);
  assign wgraynext = PTR_W'(bin2gray(GRAY_MAX_W'(wbinnext)));

  // Full means the write pointer is exactly one lap ahead of the read pointer,
  // which in Gray code is the read pointer with its two top bits inverted.
  assign full_pattern = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

  assign rbin       = PTR_W'(gray2bin(GRAY_MAX_W'(wq2_rptr)));
  assign level_next = wbinnext - rbin;

  // Advance the pointers and register the flags from the post-write pointer.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin   <= '0;
      wptr   <= '0;
      wfull  <= 1'b0;
      wafull <= 1'b0;
      wlevel <= '0;
    end else begin
      wbin   <= wbinnext;
      wptr   <= wgraynext;
      wfull  <= (wgraynext == full_pattern);
      wafull <= (level_next >= AFULL_LEVEL);
      wlevel <= level_next;
    end
  end

`ifdef WPTR_FULL_OVF_EN
  // Sticky overflow: a write attempt while full sets it; setting beats clearing.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf <= 1'b0;
    end else if (winc && wfull) begin
      wovf <= 1'b1;
    end else if (wovf_clr) begin
      wovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_wptr_full_gen.sv
// Self-checking bench for wptr_full_gen (ADDRSIZE=4, AFULL_MARGIN=2).
// The reference model tracks total writes accepted and total reads seen as
// plain integers; pointers, flags and level are derived from their difference.
// Build with WPTR_FULL_OVF_EN defined to exercise the overflow flag as well.
module tb_wptr_full_gen;

  localparam int ADDRSIZE = 4;
  localparam int DEPTH    = 16;
  localparam int MARGIN   = 2;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       winc = 1'b0;
  logic [4:0] wq2_rptr = '0;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       wafull;
  logic [4:0] wlevel;
  logic       wovf;
  logic       wovf_clr = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;
  bit check_en = 1'b0;

  // Model state
  int m_wtotal = 0;
  int rtotal   = 0;
  int m_level  = 0;
  bit m_full   = 1'b0;
  bit m_afull  = 1'b0;
  bit m_ovf    = 1'b0;

  wptr_full_gen #(.ADDRSIZE(ADDRSIZE), .AFULL_MARGIN(MARGIN)) dut (
    .wclk    (wclk),
    .wrst_n  (wrst_n),
    .winc    (winc),
    .wq2_rptr(wq2_rptr),
    .wen     (wen),
    .waddr   (waddr),
    .wptr    (wptr),
    .wfull   (wfull),
    .wafull  (wafull),
    .wlevel  (wlevel)
`ifdef WPTR_FULL_OVF_EN
    ,
    .wovf    (wovf),
    .wovf_clr(wovf_clr)
`endif
  );

`ifndef WPTR_FULL_OVF_EN
  assign wovf = 1'b0;
`endif

  always #5 wclk = ~wclk;

  function automatic logic [4:0] toGray(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic inc, input int radv, input logic clr);
    @(posedge wclk);
    #2;
    winc     = inc;
    rtotal   = rtotal + radv;
    wq2_rptr = toGray(rtotal);
    wovf_clr = clr;
  endtask

  task automatic doReset();
    @(posedge wclk);
    #2;
    wrst_n   = 1'b0;
    winc     = 1'b0;
    wovf_clr = 1'b0;
    rtotal   = 0;
    wq2_rptr = '0;
    @(posedge wclk);
    #2;
    wrst_n = 1'b1;
  endtask

  // Reference model: occupancy is writes accepted minus reads visible at the edge.
  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      m_wtotal = 0;
      m_level  = 0;
      m_full   = 1'b0;
      m_afull  = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      if (winc && m_full) m_ovf = 1'b1;
      else if (wovf_clr)  m_ovf = 1'b0;
      if (winc && !m_full) m_wtotal = m_wtotal + 1;
      m_level = m_wtotal - rtotal;
      m_full  = (m_level == DEPTH);
      m_afull = (m_level >= DEPTH - MARGIN);
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge wclk) begin
    if (check_en) begin
      checkOutput("waddr",  32'(waddr),  32'(m_wtotal % DEPTH));
      checkOutput("wptr",   32'(wptr),   32'(toGray(m_wtotal)));
      checkOutput("wlevel", 32'(wlevel), 32'(m_level));
      checkOutput("wfull",  32'(wfull),  32'(m_full));
      checkOutput("wafull", 32'(wafull), 32'(m_afull));
      checkOutput("wen",    32'(wen),    32'(winc & ~m_full));
`ifdef WPTR_FULL_OVF_EN
      checkOutput("wovf",   32'(wovf),   32'(m_ovf));
`endif
    end
  end

  initial begin
    logic [4:0] prev_wptr;
    int need;
    int target;
    int avail;

    wrst_n = 1'b0;
    repeat (2) @(posedge wclk);
    #2;
    wrst_n   = 1'b1;
    check_en = 1'b1;

    // Reset scenario: 5 writes, then asynchronous reset mid-cycle.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 0, 1'b0);
    @(posedge wclk);
    #2;
    winc = 1'b0;
    #1;
    checkOutput("pre_reset_waddr", 32'(waddr), 32'd5);
    checkOutput("pre_reset_wptr",  32'(wptr),  32'd7);
    wrst_n = 1'b0;
    #1;
    checkOutput("rst_waddr",  32'(waddr),  32'd0);
    checkOutput("rst_wptr",   32'(wptr),   32'd0);
    checkOutput("rst_wlevel", 32'(wlevel), 32'd0);
    checkOutput("rst_wfull",  32'(wfull),  32'd0);
    checkOutput("rst_wafull", 32'(wafull), 32'd0);
    @(posedge wclk);
    #2;
    wrst_n = 1'b1;

    // Fill scenario: 16 writes with the read pointer parked at 0.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 0, 1'b0);
      #1;
      checkOutput("fill_waddr", 32'(waddr), 32'(i));
      if (i == 0)  checkOutput("first_wen", 32'(wen), 32'd1);
      if (i == 13) checkOutput("fill_wafull13", 32'(wafull), 32'd0);
      if (i == 14) checkOutput("fill_wafull14", 32'(wafull), 32'd1);
      if (i == 15) checkOutput("fill_wfull15", 32'(wfull), 32'd0);
    end

    // Overfill: three more requests while full.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 0, 1'b0);
      #1;
      checkOutput("full_wfull",  32'(wfull),  32'd1);
      checkOutput("full_wptr",   32'(wptr),   32'h18);
      checkOutput("full_wlevel", 32'(wlevel), 32'd16);
      checkOutput("full_waddr",  32'(waddr),  32'd0);
      checkOutput("full_wen",    32'(wen),    32'd0);
    end
`ifdef WPTR_FULL_OVF_EN
    applyStimulus(1'b0, 0, 1'b1);
    #1;
    checkOutput("ovf_set", 32'(wovf), 32'd1);
    applyStimulus(1'b0, 0, 1'b0);
    #1;
    checkOutput("ovf_clr", 32'(wovf), 32'd0);
`endif

    // Drain visibility: read pointer jumps to 4.
    applyStimulus(1'b0, 4, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    #1;
    checkOutput("drain_wfull",  32'(wfull),  32'd0);
    checkOutput("drain_wafull", 32'(wafull), 32'd0);
    checkOutput("drain_wlevel", 32'(wlevel), 32'd12);

    // Wrap: 40 writes, read pointer trails by two cycles.
    doReset();
    prev_wptr = wptr;
    for (int i = 0; i < 40; i++) begin
      target = (i >= 2) ? i - 2 : 0;
      applyStimulus(1'b1, target - rtotal, 1'b0);
      #1;
      if (i > 0) checkOutput("wrap_onebit", 32'($countones(wptr ^ prev_wptr)), 32'd1);
      prev_wptr = wptr;
      if (i == 15) checkOutput("wrap_msb15", 32'(wptr[4]), 32'd0);
      if (i == 16) checkOutput("wrap_msb16", 32'(wptr[4]), 32'd1);
      if (i == 32) checkOutput("wrap_msb32", 32'(wptr[4]), 32'd0);
      checkOutput("wrap_nofull", 32'(wfull), 32'd0);
    end

    // Simultaneous write and read advance at level 15.
    applyStimulus(1'b0, 0, 1'b0);
    #1;
    need = 15 - m_level;
    for (int i = 0; i < need; i++) applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b1, 1, 1'b0);
    #1;
    checkOutput("simul_pre_level", 32'(wlevel), 32'd15);
    applyStimulus(1'b0, 0, 1'b0);
    #1;
    checkOutput("simul_wlevel", 32'(wlevel), 32'd15);
    checkOutput("simul_wfull",  32'(wfull),  32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      avail = m_wtotal - rtotal;
      if (avail > 2) avail = 2;
      applyStimulus(1'($urandom_range(0, 9) < 7), int'($urandom_range(0, avail)),
                    1'($urandom_range(0, 7) == 0));
    end
    applyStimulus(1'b0, 0, 1'b0);
    repeat (2) @(posedge wclk);
    check_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
